// File: rtl/mmio_host_port_pkg.sv
`default_nettype none
// ============================================================================
// mmio_host_port_pkg : register offsets and STATUS layout for the host port
// Rev 1.0
// ============================================================================
package mmio_host_port_pkg;

  localparam logic [1:0] OFF_TOHOST  = 2'd0;
  localparam logic [1:0] OFF_CONSOLE = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;
  localparam logic [1:0] OFF_CYCLE   = 2'd3;

  localparam int STATUS_COUNT_LSB = 0;
  localparam int STATUS_COUNT_W   = 4;
  localparam int STATUS_FULL_BIT  = 8;

  function automatic logic [31:0] status_word(input logic full, input logic [3:0] count);
    logic [31:0] w_word;
    w_word = '0;
    w_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count;
    w_word[STATUS_FULL_BIT] = full;
    return w_word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_host_port_sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : circular-buffer FIFO with occupancy count, no push/pop bypass
// Rev 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  localparam logic [AW:0] C_FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == C_FULL_COUNT);
  assign count     = r_count;
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;
  // Head reads as zero when empty so stale storage never leaks out.
  assign head      = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmio_host_port.sv
`default_nettype none
// ============================================================================
// mmio_host_port : simulation host device (tohost, console FIFO, cycle counter)
// Rev 1.0
// ============================================================================
module mmio_host_port
  import mmio_host_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          FIFO_AW    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        done,
  output logic [30:0] exit_code
);

  logic              w_hit;
  logic [1:0]        w_off;
  logic              w_con_wr;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_tohost_set;
  logic              w_read;
  logic [31:0]       w_rdata;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [7:0]        w_fifo_head;
  logic [FIFO_AW:0]  w_fifo_count;
  logic [3:0]        w_count4;
  logic              w_unused;

  logic [31:0]       r_cycle;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_done;
  logic [30:0]       r_exit_code;

  assign w_hit    = (req_addr[31:4] == BASE_ADDR[31:4]);
  assign w_off    = req_addr[3:2];
  assign w_con_wr = req_valid & req_we & w_hit & (w_off == OFF_CONSOLE);

  // Backpressure uses the pre-edge full flag only; a same-cycle pop does not unblock.
  assign req_ready    = ~(w_con_wr & w_fifo_full);
  assign w_accept     = req_valid & req_ready;
  assign w_push       = w_accept & w_con_wr & req_wstrb[0];
  assign w_tohost_set = w_accept & req_we & w_hit & (w_off == OFF_TOHOST) & req_wdata[0] & ~r_done;
  assign w_read       = w_accept & ~req_we;
  assign w_pop        = con_valid & con_ready;
  assign w_count4     = 4'(w_fifo_count);
  assign w_unused     = ^{req_addr[1:0], req_wstrb[3:1]};

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (w_off)
        OFF_STATUS: w_rdata = status_word(w_fifo_full, w_count4);
        OFF_CYCLE:  w_rdata = r_cycle;
        default:    w_rdata = '0;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_con_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (req_wdata[7:0]),
    .pop       (w_pop),
    .head      (w_fifo_head),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full),
    .count     (w_fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_done      <= 1'b0;
      r_exit_code <= '0;
    end else begin
      r_cycle     <= r_cycle + 32'd1;
      r_rsp_valid <= w_read;
      if (w_read) begin
        r_rsp_rdata <= w_rdata;
      end
      if (w_tohost_set) begin
        r_done      <= 1'b1;
        r_exit_code <= req_wdata[31:1];
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign done      = r_done;
  assign exit_code = r_exit_code;
  assign con_valid = ~w_fifo_empty;
  assign con_data  = w_fifo_head;

endmodule
`default_nettype wire
